// File: rtl/qa_driver_csr_decode.sv
// CSR-write decoder for the QA driver AFU: DSM base, SREG read sequencing into host DSM,
// and MMIO-read-compat requests.
module qa_driver_csr_decode #(
  parameter logic [63:0] SREG_DSM_OFFSET = 64'h40,
  parameter int unsigned RSP_TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        csr_wr_valid,
  input  logic [15:0] csr_wr_addr,
  input  logic [31:0] csr_wr_data,
  output logic        dsm_base_valid,
  output logic [63:0] dsm_base,
  output logic        sreg_req_valid,
  output logic [31:0] sreg_req_addr,
  input  logic        sreg_rsp_valid,
  input  logic [63:0] sreg_rsp_data,
  output logic        dsm_wr_valid,
  output logic [63:0] dsm_wr_addr,
  output logic [63:0] dsm_wr_data,
  input  logic        dsm_wr_ready,
  output logic        mmio_rd_valid,
  output logic [15:0] mmio_rd_addr,
  output logic [7:0]  sreg_drop_cnt
);

  localparam logic [15:0] ADDR_BASE_LO = 16'h1A00;
  localparam logic [15:0] ADDR_BASE_HI = 16'h1A04;
  localparam logic [15:0] ADDR_SREG    = 16'h1A10;
  localparam logic [15:0] ADDR_MMIO    = 16'h1A14;

  localparam int CNT_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       dsm_hi_q;

  logic wr_lo;
  logic wr_hi;
  logic wr_sreg;
  logic wr_mmio;
  logic sreg_accept;
  logic wait_done;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wr_lo   = csr_wr_valid && (csr_wr_addr == ADDR_BASE_LO);
  assign wr_hi   = csr_wr_valid && (csr_wr_addr == ADDR_BASE_HI);
  assign wr_sreg = csr_wr_valid && (csr_wr_addr == ADDR_SREG);
  assign wr_mmio = csr_wr_valid && (csr_wr_addr == ADDR_MMIO);

  assign dsm_wr_valid = (state_q == S_WRITE);

  always_comb begin
    state_d     = state_q;
    sreg_accept = 1'b0;
    wait_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_sreg && dsm_base_valid) begin
          sreg_accept = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving in the expiry cycle still completes normally.
        if (sreg_rsp_valid || (cnt_q == CNT_LAST)) begin
          wait_done = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (dsm_wr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      dsm_hi_q       <= '0;
      dsm_base       <= '0;
      dsm_base_valid <= 1'b0;
      sreg_req_valid <= 1'b0;
      sreg_req_addr  <= '0;
      dsm_wr_addr    <= '0;
      dsm_wr_data    <= '0;
      mmio_rd_valid  <= 1'b0;
      mmio_rd_addr   <= '0;
      sreg_drop_cnt  <= '0;
    end else begin
      cnt_q          <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      sreg_req_valid <= sreg_accept;
      mmio_rd_valid  <= wr_mmio;

      if (wr_hi) begin
        dsm_hi_q       <= csr_wr_data;
        dsm_base_valid <= 1'b0;
      end
      if (wr_lo) begin
        dsm_base       <= {dsm_hi_q, csr_wr_data};
        dsm_base_valid <= 1'b1;
      end

      // Write address is frozen at accept so later base rewrites cannot redirect it.
      if (sreg_accept) begin
        sreg_req_addr <= csr_wr_data;
        dsm_wr_addr   <= dsm_base + SREG_DSM_OFFSET;
      end
      if (wait_done) dsm_wr_data <= sreg_rsp_valid ? sreg_rsp_data : {64{1'b1}};

      if (wr_sreg && !sreg_accept) sreg_drop_cnt <= sat_inc8(sreg_drop_cnt);
      if (wr_mmio) mmio_rd_addr <= csr_wr_data[15:0];
    end
  end

endmodule

// File: tb/tb_qa_driver_csr_decode.sv
// Bench for qa_driver_csr_decode: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model.
module tb_qa_driver_csr_decode;

  localparam int unsigned T = 16;
  localparam logic [63:0] OFF = 64'h40;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_WRITE = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_wr_valid = 1'b0;
  logic [15:0] csr_wr_addr = '0;
  logic [31:0] csr_wr_data = '0;
  logic        dsm_base_valid;
  logic [63:0] dsm_base;
  logic        sreg_req_valid;
  logic [31:0] sreg_req_addr;
  logic        sreg_rsp_valid = 1'b0;
  logic [63:0] sreg_rsp_data = '0;
  logic        dsm_wr_valid;
  logic [63:0] dsm_wr_addr;
  logic [63:0] dsm_wr_data;
  logic        dsm_wr_ready = 1'b0;
  logic        mmio_rd_valid;
  logic [15:0] mmio_rd_addr;
  logic [7:0]  sreg_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  qa_driver_csr_decode #(.SREG_DSM_OFFSET(OFF), .RSP_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .dsm_base_valid(dsm_base_valid), .dsm_base(dsm_base),
    .sreg_req_valid(sreg_req_valid), .sreg_req_addr(sreg_req_addr),
    .sreg_rsp_valid(sreg_rsp_valid), .sreg_rsp_data(sreg_rsp_data),
    .dsm_wr_valid(dsm_wr_valid), .dsm_wr_addr(dsm_wr_addr), .dsm_wr_data(dsm_wr_data),
    .dsm_wr_ready(dsm_wr_ready),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr),
    .sreg_drop_cnt(sreg_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [63:0] m_base = '0;
  logic [31:0] m_hi = '0;
  bit          m_base_valid = 1'b0;
  int          m_phase = PH_IDLE;
  longint      m_cycle = 0;
  longint      m_enter = 0;
  logic [63:0] m_wr_addr = '0;
  logic [63:0] m_wr_data = '0;
  bit          m_req_v = 1'b0;
  logic [31:0] m_req_addr = '0;
  bit          m_mmio_v = 1'b0;
  logic [15:0] m_mmio_addr = '0;
  int          m_drop = 0;

  wire m_sreg_wr = csr_wr_valid && (csr_wr_addr == 16'h1A10);
  wire m_accept  = m_sreg_wr && (m_phase == PH_IDLE) && m_base_valid;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_base <= '0; m_hi <= '0; m_base_valid <= 1'b0; m_phase <= PH_IDLE;
      m_cycle <= 0; m_enter <= 0; m_wr_addr <= '0; m_wr_data <= '0;
      m_req_v <= 1'b0; m_req_addr <= '0; m_mmio_v <= 1'b0; m_mmio_addr <= '0; m_drop <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
      m_req_v <= m_accept;
      if (m_accept) begin
        m_phase    <= PH_WAIT;
        m_enter    <= m_cycle;
        m_req_addr <= csr_wr_data;
        m_wr_addr  <= m_base + OFF;
      end else if (m_sreg_wr) begin
        m_drop <= (m_drop >= 255) ? 255 : m_drop + 1;
      end
      if (m_phase == PH_WAIT) begin
        if (sreg_rsp_valid) begin
          m_wr_data <= sreg_rsp_data; m_phase <= PH_WRITE;
        end else if (m_cycle - m_enter == longint'(T)) begin
          m_wr_data <= '1; m_phase <= PH_WRITE;
        end
      end
      if (m_phase == PH_WRITE && dsm_wr_ready) m_phase <= PH_IDLE;
      m_mmio_v <= csr_wr_valid && (csr_wr_addr == 16'h1A14);
      if (csr_wr_valid && csr_wr_addr == 16'h1A14) m_mmio_addr <= csr_wr_data[15:0];
      if (csr_wr_valid && csr_wr_addr == 16'h1A04) begin
        m_hi <= csr_wr_data; m_base_valid <= 1'b0;
      end
      if (csr_wr_valid && csr_wr_addr == 16'h1A00) begin
        m_base <= {m_hi, csr_wr_data}; m_base_valid <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dsm_base_valid", dsm_base_valid, m_base_valid);
      chk("dsm_base", dsm_base, m_base);
      chk("sreg_req_valid", sreg_req_valid, m_req_v);
      chk("sreg_req_addr", sreg_req_addr, m_req_addr);
      chk("dsm_wr_valid", dsm_wr_valid, m_phase == PH_WRITE);
      if (m_phase == PH_WRITE) begin
        chk("dsm_wr_addr", dsm_wr_addr, m_wr_addr);
        chk("dsm_wr_data", dsm_wr_data, m_wr_data);
      end
      chk("mmio_rd_valid", mmio_rd_valid, m_mmio_v);
      chk("mmio_rd_addr", mmio_rd_addr, m_mmio_addr);
      chk("sreg_drop_cnt", sreg_drop_cnt, 64'(m_drop));
    end
  end

  // One clock of stimulus; returns 1ns after the edge that sampled it.
  task automatic cyc(input bit v, input logic [15:0] a, input logic [31:0] d,
                     input bit rv, input logic [63:0] rd, input bit rdy);
    csr_wr_valid   = v;
    csr_wr_addr    = a;
    csr_wr_data    = d;
    sreg_rsp_valid = rv;
    sreg_rsp_data  = rd;
    dsm_wr_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 64'h0, rdy);
  endtask

  task automatic set_base(input logic [31:0] hi, input logic [31:0] lo);
    cyc(1'b1, 16'h1A04, hi, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 16'h1A00, lo, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_base_valid", dsm_base_valid, 0);
    chk("reset_dsm_wr_valid", dsm_wr_valid, 0);
    chk("reset_drop_cnt", sreg_drop_cnt, 0);
    reset_n = 1'b1;
    idle(1'b0);

    // Base programming: hi write invalidates, lo write commits {hi,lo}.
    set_base(32'h0, 32'h1000);
    cyc(1'b1, 16'h1A04, 32'h1, 1'b0, 64'h0, 1'b0);
    chk("t1_valid_after_hi", dsm_base_valid, 0);
    cyc(1'b1, 16'h1A00, 32'h8000, 1'b0, 64'h0, 1'b0);
    chk("t1_base", dsm_base, 64'h1_0000_8000);
    chk("t1_valid_after_lo", dsm_base_valid, 1);

    // SREG read with response after 3 cycles, then 4 cycles of backpressure.
    set_base(32'h0, 32'h1000);
    cyc(1'b1, 16'h1A10, 32'h5, 1'b0, 64'h0, 1'b0);
    chk("t2_req_pulse", sreg_req_valid, 1);
    chk("t2_req_addr", sreg_req_addr, 5);
    idle(1'b0);
    chk("t2_req_single", sreg_req_valid, 0);
    idle(1'b0);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 64'hDEAD, 1'b0);
    chk("t2_wr_valid", dsm_wr_valid, 1);
    chk("t2_wr_addr", dsm_wr_addr, 64'h1040);
    chk("t2_wr_data", dsm_wr_data, 64'hDEAD);
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("t2_held", dsm_wr_valid, 1);
    chk("t2_held_data", dsm_wr_data, 64'hDEAD);
    idle(1'b1);
    chk("t2_released", dsm_wr_valid, 0);

    // Timeout exactly T cycles after entering WAIT.
    cyc(1'b1, 16'h1A10, 32'h7, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < int'(T) - 1; i++) idle(1'b0);
    chk("t3_not_yet", dsm_wr_valid, 0);
    idle(1'b0);
    chk("t3_timeout_valid", dsm_wr_valid, 1);
    chk("t3_timeout_data", dsm_wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1'b1);
    // Response arriving in the expiry cycle wins.
    cyc(1'b1, 16'h1A10, 32'h8, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < int'(T) - 1; i++) idle(1'b0);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 64'h1234, 1'b0);
    chk("t3_late_rsp_data", dsm_wr_data, 64'h1234);
    idle(1'b1);

    // Drops: base invalid, then busy, then saturation.
    cyc(1'b1, 16'h1A04, 32'h0, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 16'h1A10, 32'h9, 1'b0, 64'h0, 1'b0);
    chk("t4_drop1", sreg_drop_cnt, 1);
    chk("t4_no_req", sreg_req_valid, 0);
    cyc(1'b1, 16'h1A00, 32'h1000, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 16'h1A10, 32'h1, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 16'h1A10, 32'h2, 1'b0, 64'h0, 1'b0);
    chk("t4_drop2", sreg_drop_cnt, 2);
    chk("t4_no_req2", sreg_req_valid, 0);
    // Base rewrite during WAIT must not move the latched write address.
    set_base(32'h0, 32'h5000);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 64'h77, 1'b0);
    chk("t4_isolated_addr", dsm_wr_addr, 64'h1040);
    idle(1'b1);
    cyc(1'b1, 16'h1A04, 32'h0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'h1A10, 32'(i), 1'b0, 64'h0, 1'b0);
    chk("t4_saturated", sreg_drop_cnt, 255);

    // Wrapping base address, then MMIO compat write while in WRITE.
    set_base(32'hFFFF_FFFF, 32'hFFFF_FFF0);
    cyc(1'b1, 16'h1A10, 32'h3, 1'b0, 64'h0, 1'b0);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 64'hABCD, 1'b0);
    chk("t5_wrap_addr", dsm_wr_addr, 64'h30);
    cyc(1'b1, 16'h1A14, 32'h2A40, 1'b0, 64'h0, 1'b0);
    chk("t5_mmio_valid", mmio_rd_valid, 1);
    chk("t5_mmio_addr", mmio_rd_addr, 16'h2A40);
    chk("t5_fsm_kept", dsm_wr_valid, 1);
    chk("t5_data_kept", dsm_wr_data, 64'hABCD);
    idle(1'b0);
    chk("t5_mmio_pulse", mmio_rd_valid, 0);
    idle(1'b1);

    // Asynchronous reset during WRITE.
    cyc(1'b1, 16'h1A10, 32'h4, 1'b0, 64'h0, 1'b0);
    cyc(1'b0, 16'h0, 32'h0, 1'b1, 64'h55, 1'b0);
    chk("t6_in_write", dsm_wr_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_wr_valid", dsm_wr_valid, 0);
    chk("t6_async_base_valid", dsm_base_valid, 0);
    chk("t6_async_drop", sreg_drop_cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t6_no_write_after", dsm_wr_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit          v;
      logic [15:0] a;
      int          r;
      v = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    a = 16'h1A00;
        2:       a = 16'h1A04;
        3, 4, 5: a = 16'h1A10;
        6, 7:    a = 16'h1A14;
        8:       a = 16'h1A08;
        default: a = 16'($urandom);
      endcase
      cyc(v, a, $urandom, ($urandom_range(0, 5) == 0), {$urandom, $urandom},
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
